hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
Parametrised data-hazard controller for the SPARC-subset 5-stage pipeline. It replaces fixed per-operand forwarding selects with a self-tracking unit. It keeps a shadow pipeline of in-flight destination registers (EX..WB), drives the per-operand forwarding mux selects for any number of ID-stage source operands, and generates load-use stalls with bubble insertion. It sits in ID, beside the RegisterFile and the forwarding muxes.

Parameters:
NSRC, 3, number of ID source operands tracked (PA, PB, DataIn)
AW, 5, register address width
DEPTH, 3, number of tracked downstream stages (1=EX, 2=MEM, 3=WB)
LOAD_STAGE, 2, first stage index at which load data is forwardable (MEM)
CW, 16, width of stall counter
Derived: SW = $clog2(DEPTH+1), the select width; 2 bits at default.

Ports:
Clk  input  1  clock, rising edge
R  input  1  reset; asynchronous, active-low
id_valid  input  1  ID holds a real instruction
id_flush  input  1  ID instruction is being squashed (taken branch/annul)
id_rd  input  AW  ID destination register
id_we  input  1  ID instruction writes the register file
id_load  input  1  ID instruction is a load
id_src  input  NSRC*AW  packed source addresses; operand i in bits [i*AW +: AW]
id_src_used  input  NSRC  operand i is actually read
fwd_sel  output  NSRC*SW  per-operand select; 0=RF, k=stage k result
stall  output  1  hold PC/nPC/IF_ID (LE low); force control bubble into ID_EX
stall_cnt  output  CW  saturating count of stall cycles

Behaviour:
- Shadow entry per stage k=1..DEPTH holds {v, rd, we, ld}.
- Reset (R=0, asynchronous): all entries v=0. stall_cnt=0. With no valid entries, fwd_sel=0 and stall=0.
- Match(i,k) requires all of: v_k=1, we_k=1, rd_k!=0, rd_k==id_src[i], id_src_used[i]=1.
- Register 0 is never forwarded or stalled on.
- fwd_sel[i] is combinational: the smallest k with Match(i,k), else 0. The nearest producer wins.
- Load-use hazard: for some i, the winning k has ld_k=1 and k < LOAD_STAGE.
- stall = id_valid & ~id_flush & load-use hazard. The output is combinational from registered state and ID inputs.
- While stall=1, fwd_sel is still driven but is don't-care to consumers.
- Update on each rising Clk:
  - Stages 2..DEPTH take stage k-1 in all cases.
  - If stall=1: stage 1 takes a bubble (v=0).
  - Else if id_flush=1 or id_valid=0: stage 1 takes a bubble.
  - Else: stage 1 takes {1, id_rd, id_we, id_load}.
- Flush has priority over stall: a squashed instruction never stalls, and its entry is never inserted.
- Stall length: a load immediately ahead in EX with default params gives exactly 1 stall cycle. In general it is LOAD_STAGE - k cycles, held until the load reaches LOAD_STAGE.
- No combinational path from the stall output back into the shadow state except the stage-1 bubble mux.
- Reset mid-stall: all entries clear immediately and stall drops in the same cycle.
- stall_cnt increments by 1 on each Clk edge where stall=1. It saturates at all-ones and does not wrap.

Optional Feature:
HAZ_STALL_CNT_EN:
- Defined: stall_cnt counter implemented as described.
- Undefined: no counter flops; stall_cnt tied to 0.
- All other behaviour is identical either way.

Test Plan:
- Reset: drive R=0 mid-run with valid entries -> fwd_sel=0, stall=0, stall_cnt=0 immediately. All entries invalid after R returns high.
- Back-to-back ALU chain: add r3 (we=1), then next ID reads src0=r3 -> fwd_sel[0]=1 (EX). One cycle later, with an unrelated ID in between -> 2 (MEM). Then -> 3 (WB). Then -> 0.
- Nearest-producer priority: r5 written by instructions in stages 1 and 3, src1=r5 -> fwd_sel[1]=1, not 3.
- Register 0 and unused operands:
  - r0 written in EX, src0=r0 -> fwd_sel[0]=0, stall=0.
  - Matching src with id_src_used=0 -> select 0.
- Load-use: ld r8 followed by use of r8 ->
  - stall=1 for exactly 1 cycle and stage 1 gets a bubble.
  - Next cycle, stall=0 and fwd_sel=2.
  - stall_cnt increments 0->1 with HAZ_STALL_CNT_EN; stays 0 without it.
- Flush precedence: load-use condition with id_flush=1 -> stall=0 and no entry inserted. Three edges later, all stages are v=0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Data-hazard controller for a 5-stage SPARC-subset pipeline, placed in ID.
// It keeps a shadow copy of the destination register of every in-flight
// instruction from EX to WB. For each ID source operand it picks the forwarding
// mux select, and it stalls ID when a load result is needed before the load can
// forward it.
// Optional feature macro: HAZ_STALL_CNT_EN. When it is defined, a saturating
// stall-cycle counter drives stall_cnt. When it is not defined, stall_cnt is 0.
module hazard_forward_unit #(
   parameter int NSRC       = 3,
   parameter int AW         = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int CW         = 16,
   localparam int SW        = $clog2(DEPTH + 1)
) (
   input  logic                Clk,
   input  logic                R,
   input  logic                id_valid,
   input  logic                id_flush,
   input  logic [AW-1:0]       id_rd,
   input  logic                id_we,
   input  logic                id_load,
   input  logic [NSRC*AW-1:0]  id_src,
   input  logic [NSRC-1:0]     id_src_used,
   output logic [NSRC*SW-1:0]  fwd_sel,
   output logic                stall,
   output logic [CW-1:0]       stall_cnt
);

   // Shadow pipeline. Index k is the stage: 1 = EX, 2 = MEM, 3 = WB.
   logic          r_v  [1:DEPTH];
   logic [AW-1:0] r_rd [1:DEPTH];
   logic          r_we [1:DEPTH];
   logic          r_ld [1:DEPTH];

   // One bit per operand: the winning producer is a load that cannot forward yet.
   logic [NSRC-1:0] w_lu;
   logic            w_bubble;

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         logic [AW-1:0] w_addr;
         logic [SW-1:0] w_sel;
         logic          w_ld_early;

         assign w_addr = id_src[gi*AW +: AW];

         // Find the nearest matching producer. The scan runs from the farthest
         // stage to the nearest, so the last match written is the smallest k.
         always_comb begin
            w_sel      = '0;
            w_ld_early = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
               if (r_v[k] && r_we[k] && (r_rd[k] != '0) &&
                   (r_rd[k] == w_addr) && id_src_used[gi]) begin
                  w_sel      = SW'(k);
                  w_ld_early = r_ld[k] && (k < LOAD_STAGE);
               end
            end
         end

         assign fwd_sel[gi*SW +: SW] = w_sel;
         assign w_lu[gi]             = w_ld_early;
      end
   endgenerate

   // A squashed or empty ID slot never stalls.
   assign stall    = id_valid & ~id_flush & (|w_lu);
   assign w_bubble = stall | id_flush | ~id_valid;

   // Advance the shadow pipeline. Stage 1 gets either the ID instruction or a bubble.
   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         for (int k = 1; k <= DEPTH; k++) begin
            r_v[k]  <= 1'b0;
            r_rd[k] <= '0;
            r_we[k] <= 1'b0;
            r_ld[k] <= 1'b0;
         end
      end else begin
         for (int k = 2; k <= DEPTH; k++) begin
            r_v[k]  <= r_v[k-1];
            r_rd[k] <= r_rd[k-1];
            r_we[k] <= r_we[k-1];
            r_ld[k] <= r_ld[k-1];
         end
         r_v[1]  <= ~w_bubble;
         r_rd[1] <= id_rd;
         r_we[1] <= id_we;
         r_ld[1] <= id_load;
      end
   end

`ifdef HAZ_STALL_CNT_EN
   logic [CW-1:0] r_stall_cnt;

   // Count stall cycles. The counter holds at all-ones instead of wrapping.
   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         r_stall_cnt <= '0;
      end else if (stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule
